icache: RTL

Direct-mapped, one-word-per-line instruction cache between the instruction fetch stage (upstream consumer) and the memory controller (byte-wide backing store). It accepts one fetch request at a time, returns the 32-bit instruction in one cycle on a hit, and on a miss fetches four bytes little-endian, fills the line, and forwards the word. It is the block that drives the fetch stage's `iIC_En`/`iIC_Ins` inputs.

---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_ram.sv | 48 ++++
 rtl/icache.sv | 110 +++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared widths and FSM state type for the instruction cache.
package icache_pkg;

  localparam int unsigned REG_DAT_W    = 32;
  localparam int unsigned INS_DAT_W    = 32;
  localparam int unsigned ICACHE_IDX_W = 8;
  localparam int unsigned MEM_DAT_W    = 8;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_MREQ = 2'd1,
    IC_FILL = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_ram.sv
// Tag/valid/data storage for the direct-mapped icache.
// One combinational read port and one write port. Only the valid bits are reset.
module icache_ram
  import icache_pkg::*;
#(
  parameter int unsigned IDX_W = ICACHE_IDX_W,
  parameter int unsigned TAG_W = 30 - IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [INS_DAT_W-1:0] rd_dat,
  input  logic                 we,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [INS_DAT_W-1:0] wr_dat
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]     valid;
  logic [TAG_W-1:0]     tag_mem [DEPTH];
  logic [INS_DAT_W-1:0] dat_mem [DEPTH];

  // Valid bits: cleared on reset, set when a line is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: written on fill.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx] <= wr_tag;
      dat_mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_dat   = dat_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Hit returns in one cycle. A miss fetches four bytes, little-endian, from the
// memory controller, fills the line and forwards the assembled word.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned IDX_W = ICACHE_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iIF_En,
  input  logic [REG_DAT_W-1:0] iIF_Pc,
  output logic                 oIF_En,
  output logic [INS_DAT_W-1:0] oIF_Ins,
  output logic                 oMC_En,
  output logic [REG_DAT_W-1:0] oMC_Addr,
  input  logic                 iMC_En,
  input  logic [MEM_DAT_W-1:0] iMC_Dat
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  ic_state_e                  state;
  logic [1:0]                 cnt;
  logic [3*MEM_DAT_W-1:0]     sbuf;
  logic                       rd_valid;
  logic [TAG_W-1:0]           rd_tag;
  logic [INS_DAT_W-1:0]       rd_dat;
  logic                       hit;
  logic                       we;
  logic [INS_DAT_W-1:0]       fill_word;
  logic                       pc_lsb_unused;

  // Byte offset within the word has no effect on lookup.
  assign pc_lsb_unused = ^iIF_Pc[1:0];

  assign hit = rd_valid && (rd_tag == iIF_Pc[31:IDX_W+2]);

  // Bytes shift in from the top, so after three bytes sbuf holds
  // {b2,b1,b0} and the fourth byte completes the word directly.
  assign fill_word = {iMC_Dat, sbuf};

  // oMC_Addr already holds the latched miss address for the whole fill.
  assign we = en && !rst && (state == IC_FILL) && iMC_En && (cnt == 2'd3);

  icache_ram #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (iIF_Pc[IDX_W+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_dat   (rd_dat),
    .we       (we),
    .wr_idx   (oMC_Addr[IDX_W+1:2]),
    .wr_tag   (oMC_Addr[31:IDX_W+2]),
    .wr_dat   (fill_word)
  );

  // Lookup/miss/fill FSM with registered fetch and memory-request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IC_IDLE;
      cnt      <= '0;
      sbuf     <= '0;
      oIF_En   <= 1'b0;
      oIF_Ins  <= '0;
      oMC_En   <= 1'b0;
      oMC_Addr <= '0;
    end else if (en) begin
      oIF_En <= 1'b0;
      oMC_En <= 1'b0;
      unique case (state)
        IC_IDLE: begin
          if (iIF_En) begin
            if (hit) begin
              oIF_En  <= 1'b1;
              oIF_Ins <= rd_dat;
            end else begin
              // Request pulse is raised here so it is visible for the whole MREQ cycle.
              oMC_En   <= 1'b1;
              oMC_Addr <= {iIF_Pc[31:2], 2'b00};
              state    <= IC_MREQ;
            end
          end
        end
        IC_MREQ: begin
          cnt   <= '0;
          state <= IC_FILL;
        end
        IC_FILL: begin
          if (iMC_En) begin
            sbuf <= {iMC_Dat, sbuf[3*MEM_DAT_W-1:MEM_DAT_W]};
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              oIF_En  <= 1'b1;
              oIF_Ins <= fill_word;
              state   <= IC_IDLE;
            end
          end
        end
        default: state <= IC_IDLE;
      endcase
    end
  end

endmodule
